// File: rtl/risc_sequencer_pkg.sv
// Shared encodings for the accumulator CPU control sequencer: opcodes, phases,
// top-level modes and the packed control vector driven each phase.
package risc_sequencer_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_HALTED = 2'd1,
        MODE_WAIT   = 2'd2
    } mode_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic ld_ac;
        logic inc_pc;
        logic ld_pc;
        logic data_e;
        logic halt;
        logic instr_done;
    } ctrl_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/risc_phase_decode.sv
// Pure combinational map from (mode, phase, opcode, zero) to the control
// vector and the externally visible phase index.
module risc_phase_decode
    import risc_sequencer_pkg::*;
(
    input  mode_e      mode,
    input  logic [2:0] phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl,
    output logic [2:0] phase_out
);

    logic alu_s;
    assign alu_s = is_aluop(opcode);

    // Per-phase control decode; HALTED and WAIT override the phase index.
    always_comb begin
        ctrl      = '0;
        phase_out = phase;
        case (mode)
            MODE_RUN: begin
                case (phase)
                    PH_INST_ADDR: begin
                        ctrl.sel = 1'b1;
                    end
                    PH_INST_FETCH: begin
                        ctrl.sel = 1'b1;
                        ctrl.rd  = 1'b1;
                    end
                    PH_INST_LOAD, PH_IDLE: begin
                        ctrl.sel   = 1'b1;
                        ctrl.rd    = 1'b1;
                        ctrl.ld_ir = 1'b1;
                    end
                    PH_OP_ADDR: begin
                        ctrl.inc_pc = 1'b1;
                        ctrl.halt   = (opcode == OP_HLT);
                    end
                    PH_OP_FETCH: begin
                        ctrl.rd = alu_s;
                    end
                    PH_ALU_OP: begin
                        ctrl.rd     = alu_s;
                        ctrl.inc_pc = (opcode == OP_SKZ) && zero;
                        ctrl.ld_pc  = (opcode == OP_JMP);
                        ctrl.data_e = (opcode == OP_STO);
                    end
                    PH_STORE: begin
                        ctrl.rd         = alu_s;
                        ctrl.ld_ac      = alu_s;
                        ctrl.ld_pc      = (opcode == OP_JMP);
                        ctrl.wr         = (opcode == OP_STO);
                        ctrl.data_e     = (opcode == OP_STO);
                        ctrl.instr_done = 1'b1;
                    end
                    default: begin
                        ctrl = '0;
                    end
                endcase
            end
            MODE_HALTED: begin
                ctrl.halt = 1'b1;
                phase_out = PH_OP_ADDR;
            end
            MODE_WAIT: begin
                phase_out = PH_INST_ADDR;
            end
            default: begin
                ctrl      = '0;
                phase_out = PH_INST_ADDR;
            end
        endcase
    end

endmodule

// File: rtl/risc_sequencer.sv
// Control sequencer for the 8-bit accumulator CPU: mode/phase FSM with
// halt, resume and single-step control, plus a retired-instruction counter.
module risc_sequencer
    import risc_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             run,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             sel,
    output logic             rd,
    output logic             wr,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             data_e,
    output logic             halt,
    output logic [2:0]       phase,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    mode_e            mode_q, mode_d;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_s;
    ctrl_t            ctrl_s;

    // Next mode/phase; HLT counts as retired on HALTED entry.
    always_comb begin
        mode_d   = mode_q;
        phase_d  = phase_q;
        retire_s = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                if ((phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
                    mode_d   = MODE_HALTED;
                    retire_s = 1'b1;
                end else if (phase_q == PH_STORE) begin
                    retire_s = 1'b1;
                    phase_d  = PH_INST_ADDR;
                    mode_d   = step_mode ? MODE_WAIT : MODE_RUN;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            MODE_HALTED: begin
                if (run) begin
                    mode_d  = MODE_RUN;
                    phase_d = PH_INST_ADDR;
                end else begin
                    phase_d = PH_OP_ADDR;
                end
            end
            MODE_WAIT: begin
                if (step_req) begin
                    mode_d = MODE_RUN;
                end else begin
                    mode_d = MODE_WAIT;
                end
                phase_d = PH_INST_ADDR;
            end
            default: begin
                mode_d  = MODE_RUN;
                phase_d = PH_INST_ADDR;
            end
        endcase
        if (retire_s) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_RUN;
            phase_q   <= PH_INST_ADDR;
            retired_q <= '0;
        end else begin
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            retired_q <= retired_d;
        end
    end

    risc_phase_decode u_decode (
        .mode      (mode_q),
        .phase     (phase_q),
        .opcode    (opcode),
        .zero      (zero),
        .ctrl      (ctrl_s),
        .phase_out (phase)
    );

    assign sel        = ctrl_s.sel;
    assign rd         = ctrl_s.rd;
    assign wr         = ctrl_s.wr;
    assign ld_ir      = ctrl_s.ld_ir;
    assign ld_ac      = ctrl_s.ld_ac;
    assign inc_pc     = ctrl_s.inc_pc;
    assign ld_pc      = ctrl_s.ld_pc;
    assign data_e     = ctrl_s.data_e;
    assign halt       = ctrl_s.halt;
    assign instr_done = ctrl_s.instr_done;
    assign retired    = retired_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench for risc_sequencer: a behavioural model predicts the full
// output vector for each cycle; predictions are queued and compared after the edge.
module tb_risc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       run = 1'b0;
    logic       step_mode = 1'b0;
    logic       step_req = 1'b0;
    logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, instr_done;
    logic [2:0] phase;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0 = RUN, 1 = HALTED, 2 = WAIT.
    int         m_mode  = 0;
    int         m_phase = 0;
    logic [7:0] m_ret   = 8'd0;
    logic [20:0] exp_q[$];

    risc_sequencer #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .run        (run),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .sel        (sel),
        .rd         (rd),
        .wr         (wr),
        .ld_ir      (ld_ir),
        .ld_ac      (ld_ac),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .data_e     (data_e),
        .halt       (halt),
        .phase      (phase),
        .instr_done (instr_done),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    logic [20:0] obs_s;
    assign obs_s = {phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, instr_done, retired};

    task automatic check_val(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h (ph=%0d ctl=%b ret=%0d) want %h (ph=%0d ctl=%b ret=%0d)",
                     tag, obs, obs[20:18], obs[17:8], obs[7:0], exp, exp[20:18], exp[17:8], exp[7:0]);
        end
    endtask

    function automatic logic [20:0] model_out(input int m, input int ph, input logic [2:0] op,
                                              input logic z, input logic [7:0] ret);
        logic [2:0] po;
        logic s, r, w, lir, lac, ipc, lpc, de, h, d, alu;
        s = 1'b0; r = 1'b0; w = 1'b0; lir = 1'b0; lac = 1'b0;
        ipc = 1'b0; lpc = 1'b0; de = 1'b0; h = 1'b0; d = 1'b0;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (m == 1) begin
            h  = 1'b1;
            po = 3'd4;
        end else if (m == 2) begin
            po = 3'd0;
        end else begin
            po  = 3'(ph);
            s   = (ph <= 3);
            r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
            lir = (ph == 2) || (ph == 3);
            lac = (ph == 7) && alu;
            ipc = (ph == 4) || (ph == 6 && op == 3'd1 && z);
            lpc = (ph == 6 || ph == 7) && (op == 3'd7);
            de  = (ph == 6 || ph == 7) && (op == 3'd6);
            w   = (ph == 7) && (op == 3'd6);
            h   = (ph == 4) && (op == 3'd0);
            d   = (ph == 7);
        end
        return {po, s, r, w, lir, lac, ipc, lpc, de, h, d, ret};
    endfunction

    // Advance model with current inputs, queue prediction, clock DUT, compare.
    task automatic tick(input string tag);
        if (rst) begin
            m_mode = 0; m_phase = 0; m_ret = 8'd0;
        end else if (m_mode == 0) begin
            if (m_phase == 4 && opcode == 3'd0) begin
                m_mode = 1; m_ret = m_ret + 8'd1;
            end else if (m_phase == 7) begin
                m_ret = m_ret + 8'd1; m_phase = 0;
                if (step_mode) m_mode = 2;
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (m_mode == 1) begin
            if (run) begin m_mode = 0; m_phase = 0; end
        end else begin
            if (step_req) begin m_mode = 0; m_phase = 0; end
        end
        exp_q.push_back(model_out(m_mode, m_phase, opcode, zero, m_ret));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check_val(tag, obs_s, exp_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) tick("reset");
        rst = 1'b0;

        opcode = 3'd2; zero = 1'b0;
        repeat (8) tick("add");
        opcode = 3'd1; zero = 1'b1;
        repeat (8) tick("skz_z1");
        zero = 1'b0;
        repeat (8) tick("skz_z0");
        opcode = 3'd6;
        repeat (8) tick("sto");
        opcode = 3'd7; run = 1'b1;
        repeat (8) tick("jmp_run_ignored");
        run = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            opcode = 3'(k); zero = 1'($urandom_range(0, 1));
            repeat (8) tick("alu_ops");
        end

        opcode = 3'd0;
        repeat (5) tick("hlt_enter");
        repeat (20) tick("halted");
        run = 1'b1;
        tick("resume");
        run = 1'b0; opcode = 3'd2;
        repeat (8) tick("after_resume");

        step_mode = 1'b1;
        repeat (8) tick("step_to_wait");
        repeat (10) tick("wait_hold");
        step_req = 1'b1;
        repeat (9) tick("step_held");
        step_req = 1'b0;
        repeat (3) tick("wait_again");
        step_req = 1'b1;
        tick("step_one");
        step_req = 1'b0;
        repeat (5) tick("to_phase5");
        rst = 1'b1; run = 1'b1; step_req = 1'b1;
        tick("rst_mid");
        rst = 1'b0; run = 1'b0; step_req = 1'b0; step_mode = 1'b0;
        tick("after_rst");

        for (int i = 0; i < 2200; i++) begin
            opcode = 3'($urandom_range(1, 7));
            zero   = 1'($urandom_range(0, 1));
            tick("wrap_run");
        end

        for (int i = 0; i < 600; i++) begin
            opcode    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            run       = ($urandom_range(0, 3) == 0);
            step_mode = ($urandom_range(0, 7) == 0);
            step_req  = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
